// File: rtl/bitcount_pkg.sv
// Shared types for the Zbb count unit: operation codes and the request record.
package bitcount_pkg;

    localparam int XLEN  = 32;
    localparam int TAG_W = 5;

    typedef enum logic [1:0] {
        BC_CTZ  = 2'b00,
        BC_CLZ  = 2'b01,
        BC_CPOP = 2'b10,
        BC_RSVD = 2'b11
    } bc_op_e;

    typedef struct packed {
        bc_op_e            op;
        logic [XLEN-1:0]   operand;
        logic [TAG_W-1:0]  tag;
    } bc_req_t;

endpackage

// File: rtl/ctz.sv
// Single-cycle count-trailing-zeros of a 32-bit word; a zero word counts as 32.
module ctz (
    input  logic [31:0] operand,
    output logic [5:0]  count
);

    // Scan from the MSB down so the last hit is the lowest set bit.
    always_comb begin
        count = 6'd32;
        for (int i = 31; i >= 0; i--) begin
            if (operand[i]) begin
                count = 6'(i);
            end
        end
    end

endmodule

// File: rtl/popcount32.sv
// Combinational population count: nibble sums, then 8-, 16- and 32-bit partial sums.
module popcount32 (
    input  logic [31:0] operand,
    output logic [5:0]  count
);

    logic [2:0] sum4  [8];
    logic [3:0] sum8  [4];
    logic [4:0] sum16 [2];

    genvar gi;
    for (gi = 0; gi < 8; gi++) begin : g_sum4
        assign sum4[gi] = 3'(operand[4*gi])   + 3'(operand[4*gi+1])
                        + 3'(operand[4*gi+2]) + 3'(operand[4*gi+3]);
    end

    for (gi = 0; gi < 4; gi++) begin : g_sum8
        assign sum8[gi] = {1'b0, sum4[2*gi]} + {1'b0, sum4[2*gi+1]};
    end

    for (gi = 0; gi < 2; gi++) begin : g_sum16
        assign sum16[gi] = {1'b0, sum8[2*gi]} + {1'b0, sum8[2*gi+1]};
    end

    assign count = {1'b0, sum16[0]} + {1'b0, sum16[1]};

endmodule

// File: rtl/bitcount_unit.sv
// Two-stage ctz/clz/cpop unit: S1 captures the prepared operand, S2 counts into the
// output register. Only two valid bits; backpressure propagates combinationally.
module bitcount_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [XLEN-1:0]  in_operand,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag
);
    import bitcount_pkg::*;

    logic             vld_p1;
    bc_op_e           op_p1;
    logic [XLEN-1:0]  operand_p1;
    logic [TAG_W-1:0] tag_p1;

    logic             vld_p2;
    logic [5:0]       cnt_p2;
    logic [TAG_W-1:0] tag_p2;

    logic [XLEN-1:0]  rev_p0;
    logic [XLEN-1:0]  prep_p0;
    logic [5:0]       ctz_cnt;
    logic [5:0]       pop_cnt;
    logic [5:0]       cnt_s2;
    logic             load_out;
    logic             s1_adv;
    logic             accept;

    // Handshake: the output register frees up when empty or being taken; S1 follows it.
    assign load_out = !vld_p2 || out_ready;
    assign s1_adv   = vld_p1 && load_out;
    assign in_ready = !flush && (!vld_p1 || s1_adv);
    assign accept   = in_valid && in_ready;

    // ---- S0 -> S1: clz is ctz of the bit-reversed operand ----
    genvar gi;
    for (gi = 0; gi < XLEN; gi++) begin : g_rev
        assign rev_p0[gi] = in_operand[XLEN-1-gi];
    end

    assign prep_p0 = (bc_op_e'(in_op) == BC_CLZ) ? rev_p0 : in_operand;

    // S1 register: valid bit plus the prepared request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1     <= 1'b0;
            op_p1      <= BC_CTZ;
            operand_p1 <= '0;
            tag_p1     <= '0;
        end else begin
            if (flush) begin
                vld_p1 <= 1'b0;
            end else if (accept) begin
                vld_p1 <= 1'b1;
            end else if (s1_adv) begin
                vld_p1 <= 1'b0;
            end
            if (accept) begin
                op_p1      <= bc_op_e'(in_op);
                operand_p1 <= prep_p0;
                tag_p1     <= in_tag;
            end
        end
    end

    // ---- S1 -> S2: both counters run in parallel, op selects ----
    ctz u_ctz (
        .operand (operand_p1),
        .count   (ctz_cnt)
    );

    popcount32 u_popcount (
        .operand (operand_p1),
        .count   (pop_cnt)
    );

    // Result select; the reserved op yields zero.
    always_comb begin
        cnt_s2 = 6'd0;
        case (op_p1)
            BC_CTZ, BC_CLZ: cnt_s2 = ctz_cnt;
            BC_CPOP:        cnt_s2 = pop_cnt;
            default:        cnt_s2 = 6'd0;
        endcase
    end

    // Output register: payload only changes when a new result moves in, so a held
    // result stays stable until taken.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p2 <= 1'b0;
            cnt_p2 <= '0;
            tag_p2 <= '0;
        end else begin
            if (flush) begin
                vld_p2 <= 1'b0;
            end else if (load_out) begin
                vld_p2 <= vld_p1;
            end
            if (s1_adv && !flush) begin
                cnt_p2 <= cnt_s2;
                tag_p2 <= tag_p1;
            end
        end
    end

    assign out_valid  = vld_p2;
    assign out_result = {{(XLEN-6){1'b0}}, cnt_p2};
    assign out_tag    = tag_p2;

endmodule
